// File: rtl/ubip_frame_dec_if.sv
// ubip_frame_dec_if: control, bitstream and result handshake bundle for the unary frame decoder
interface ubip_frame_dec_if #(parameter int FRAME_LOG2 = 8);
    logic                  iStart;
    logic                  iCont;
    logic                  iBit;
    logic                  iReady;
    logic                  iClrOvr;
    logic [FRAME_LOG2:0]   oOnes;
    logic [FRAME_LOG2+1:0] oVal;
    logic                  oValid;
    logic                  oBusy;
    logic                  oOvr;
    modport master (output iStart, iCont, iBit, iReady, iClrOvr,
                    input  oOnes, oVal, oValid, oBusy, oOvr);
    modport slave  (input  iStart, iCont, iBit, iReady, iClrOvr,
                    output oOnes, oVal, oValid, oBusy, oOvr);
endinterface

// File: rtl/ubip_frame_dec.sv
// ubip_frame_dec: counts ones over 2^FRAME_LOG2-cycle frames of a bipolar unary stream and
// reports the count and its signed bipolar value through a valid/ready result register
module ubip_frame_dec #(parameter int FRAME_LOG2 = 8) (
    input logic            iClk,
    input logic            iRstN,
    ubip_frame_dec_if.slave bus
);
    typedef enum logic {IDLE, ACC} state_e;
    localparam logic [FRAME_LOG2+1:0] N_EXT = (FRAME_LOG2+2)'(1) << FRAME_LOG2;

    state_e                state_q, state_d;
    logic [FRAME_LOG2-1:0] cnt_q, cnt_d;
    logic [FRAME_LOG2:0]   ones_q, ones_d, res_ones_q, res_ones_d, ones_sum;
    logic [FRAME_LOG2+1:0] res_val_q, res_val_d;
    logic                  valid_q, valid_d, ovr_q, ovr_d, last;

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ones_q     <= '0;
            res_ones_q <= '0;
            res_val_q  <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ones_q     <= ones_d;
            res_ones_q <= res_ones_d;
            res_val_q  <= res_val_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE ? (bus.iStart ? ACC : IDLE) : (last && !bus.iCont ? IDLE : ACC);
    end

    // the frame counter wraps to zero on the last sample, so back-to-back frames need no gap cycle
    always_comb begin
        last       = state_q == ACC && &cnt_q;
        ones_sum   = ones_q + (FRAME_LOG2+1)'(bus.iBit);
        cnt_d      = state_q == ACC ? cnt_q + FRAME_LOG2'(1) : '0;
        ones_d     = state_q == ACC && !last ? ones_sum : '0;
        res_ones_d = last ? ones_sum : res_ones_q;
        res_val_d  = last ? {ones_sum, 1'b0} - N_EXT : res_val_q;
        valid_d    = last || (valid_q && !bus.iReady);
        ovr_d      = (last && valid_q && !bus.iReady) || (ovr_q && !bus.iClrOvr);
    end

    always_comb begin
        bus.oOnes  = res_ones_q;
        bus.oVal   = res_val_q;
        bus.oValid = valid_q;
        bus.oBusy  = state_q == ACC;
        bus.oOvr   = ovr_q;
    end
endmodule

// File: doc/ubip_frame_dec.md
UBIP_FRAME_DEC -- requirements
Module: ubip_frame_dec

Interface
REQ-001 SHALL have parameter FRAME_LOG2, default 8, meaning frame length N = 2^FRAME_LOG2 bitstream cycles.
REQ-002 SHALL have ports: iClk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have ports: iRstN  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports: iStart  input  1  begin frame decode when idle.
REQ-005 SHALL have ports: iCont  input  1  sampled at frame end; 1 = start next frame immediately.
REQ-006 SHALL have ports: iBit  input  1  bipolar unary bitstream sample (e.g. subtractor oC).
REQ-007 SHALL have ports: iReady  input  1  downstream accepts result when high with oValid.
REQ-008 SHALL have ports: iClrOvr  input  1  clears sticky overrun flag.
REQ-009 SHALL have ports: oOnes  output  FRAME_LOG2+1  unsigned ones count of last completed frame.
REQ-010 SHALL have ports: oVal  output  FRAME_LOG2+2  signed two's-complement bipolar value 2*oOnes - N.
REQ-011 SHALL have ports: oValid  output  1  result held in oOnes/oVal is new and unaccepted.
REQ-012 SHALL have ports: oBusy  output  1  high while a frame is being accumulated.
REQ-013 SHALL have ports: oOvr  output  1  sticky: unaccepted result was overwritten.

Function
REQ-014 SHALL implement FSM states IDLE, ACC; all outputs registered.
REQ-015 IDLE: iStart=1 at an edge SHALL move to ACC and clear ones counter and frame counter; iStart ignored in ACC.
REQ-016 ACC: each edge SHALL add iBit to ones counter (FRAME_LOG2+1 bits, no wrap; max N) and increment frame counter (FRAME_LOG2 bits).
REQ-017 The edge sampling the N-th bit (frame counter = N-1) SHALL load oOnes = final count including that bit, oVal = 2*oOnes - N, and set oValid; oValid visible the cycle after that edge (latency 1 after last sample, N+1 cycles after iStart edge).
REQ-018 At that same edge, iCont=1 SHALL stay in ACC with counters cleared so the next sample belongs to the new frame (no gap cycle); iCont=0 SHALL return to IDLE.
REQ-019 oBusy SHALL equal (state == ACC).
REQ-020 oValid&iReady at an edge with no frame completion SHALL clear oValid; oOnes/oVal hold their values.
REQ-021 Frame completion with oValid=1 and iReady=0 SHALL overwrite oOnes/oVal, keep oValid=1, set oOvr.
REQ-022 Frame completion with oValid=1 and iReady=1 in the same edge SHALL load the new result, keep oValid=1, not set oOvr.
REQ-023 oOvr SHALL clear only on iClrOvr=1 or reset; iClrOvr and an overrun event at the same edge SHALL leave oOvr=1.
REQ-024 oVal arithmetic SHALL be exact: range -N..+N, sign-correct at both extremes.

Reset
REQ-025 iRstN=0 at an edge SHALL force IDLE, counters 0, oOnes=0, oVal=0, oValid=0, oBusy=0, oOvr=0, regardless of state or other inputs.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; no oValid for it after release.
REQ-027 After release, block SHALL stay IDLE until iStart=1.

Verification (FRAME_LOG2=8 unless noted)
REQ-028 iStart pulse, iBit=1 for 256 cycles, iReady=1 -> oOnes=256, oVal=+256, oValid high exactly 1 cycle, 257 cycles after start edge.
REQ-029 iStart, iBit=0 for 256 cycles -> oOnes=0, oVal=-256; alternating 1/0 -> oOnes=128, oVal=0.
REQ-030 iCont=1, iReady=0, frames of all-ones then all-zeros -> after 2nd frame oOnes=0, oVal=-256, oValid=1, oOvr=1; iClrOvr pulse -> oOvr=0.
REQ-031 iCont=1, iReady pulsed exactly on 2nd frame completion edge -> oValid stays 1, oOvr=0, no dead cycle between frames (oBusy constant 1).
REQ-032 iRstN=0 after 100 samples -> next cycle all outputs 0, IDLE; no oValid until new iStart plus 256 samples.
REQ-033 FRAME_LOG2=2: exhaustive all 16 four-bit patterns -> oOnes = popcount, oVal = 2*popcount-4 each.
